// File: rtl/ahb_sram_if.sv
// ahb_sram_if: AHB-Lite bus bundle between a data-side master and the SRAM slave.
interface ahb_sram_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hburst, hwrite, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave on a word-wide SRAM with wait states, byte lanes and ERROR responses.
module ahb_sram_slave #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    ahb_sram_if.slave s
);
    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t                state, nxt;
    logic [31:0]           mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [1:0]            size_q;
    logic                  wr_q;
    logic [3:0]            cnt;
    logic [31:0]           rdata_q;
    logic [3:0]            be;
    logic                  can_acc, acc, legal;

    assign can_acc = state inside {IDLE, DATA, ERR2};
    assign acc     = can_acc & s.hsel & s.hready & s.htrans[1];
    assign legal   = (s.hsize <= 3'd2)
                   && !(s.hsize == 3'd1 && s.haddr[0])
                   && !(s.hsize == 3'd2 && s.haddr[1:0] != 2'b00)
                   && (s.haddr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    always_comb begin
        nxt = !acc ? (state == WAIT ? (cnt == 4'd0 ? DATA : WAIT) : state == ERR1 ? ERR2 : IDLE)
            : !legal ? ERR1
            : (WAIT_STATES == 0) ? DATA : WAIT;
    end

    always_comb begin
        be = size_q == 2'd0 ? 4'b0001 << addr_q[1:0]
           : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011)
           : 4'b1111;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s.hreadyout <= 1'b1;
            s.hresp     <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wr_q        <= 1'b0;
            cnt         <= '0;
            rdata_q     <= '0;
        end else begin
            state       <= nxt;
            s.hreadyout <= !(nxt inside {WAIT, ERR1});
            s.hresp     <= nxt inside {ERR1, ERR2};
            cnt         <= acc ? 4'(WAIT_STATES - 1) : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
            if (acc) begin
                addr_q <= s.haddr[ADDR_WIDTH+1:0];
                size_q <= s.hsize[1:0];
                wr_q   <= s.hwrite;
            end
            if (state == DATA && !wr_q) rdata_q <= s.hrdata;
        end
    end

    // Writes commit at the edge ending DATA, so a pipelined read of the same word sees them.
    always_ff @(posedge clk) begin
        if (state == DATA && wr_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= s.hwdata[8*i +: 8];
    end

    assign s.hrdata = (state == DATA && !wr_q) ? mem[addr_q[ADDR_WIDTH+1:2]] : rdata_q;
endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave wrapping a word-organised on-chip data SRAM.
- Directly downstream of the CPU data-side AHB master, reached through the bus arbiter/decoder; it consumes the single (SINGLE-burst) load/store transfers that master issues.
- Pipelined address/data phases, configurable wait states, byte/half/word writes via byte lanes.
- ERROR response on illegal transfers.

Parameters:
- ADDR_WIDTH, 12, word-address bits; capacity 2^ADDR_WIDTH words (default 16 KiB).
- BASE_ADDR, 32'h1000_0000, byte base address; must be aligned to 2^(ADDR_WIDTH+2).
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- S_HSEL  in  1  slave select from the decoder.
- S_HADDR  in  32  byte address.
- S_HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- S_HSIZE  in  3  0 byte, 1 half, 2 word; all others are illegal.
- S_HBURST  in  3  ignored; every transfer is treated independently.
- S_HWRITE  in  1  1 write, 0 read.
- S_HWDATA  in  32  write data, valid in the data phase.
- S_HREADY  in  1  bus-level ready; an address phase is sampled only when this is high.
- S_HREADYOUT  out  1  this slave's ready.
- S_HRESP  out  1  0 OKAY, 1 ERROR.
- S_HRDATA  out  32  read data.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, S_HREADYOUT=1, S_HRESP=0, S_HRDATA=0, all captured registers cleared. SRAM contents are not reset.

Address-phase acceptance:
- Accept when S_HSEL & S_HREADY & S_HTRANS[1] at a rising edge.
- On accept, register addr, size, write and the legality result.
- IDLE/BUSY or unselected cycles produce no transfer and give a zero-wait OKAY.

Legality (illegal means ERROR, no SRAM write):
- S_HSIZE > 2.
- Half-word with addr[0]=1.
- Word with addr[1:0]≠0.
- addr[31:ADDR_WIDTH+2] ≠ BASE_ADDR[31:ADDR_WIDTH+2].

States: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
  - Legal accept with WAIT_STATES=0 → DATA.
  - Legal accept with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
  - Illegal accept → ERR1.
- WAIT: HREADYOUT=0, HRESP=0; counter decrements; → DATA when the counter reaches 0.
- DATA: HREADYOUT=1, HRESP=0; the transfer completes at this edge.
  - Write: merge S_HWDATA byte lanes into the word at addr[ADDR_WIDTH+1:2].
    - Byte: lane addr[1:0].
    - Half: lanes {addr[1],0}+1..0.
    - Word: all four lanes.
  - Read: S_HRDATA = full aligned 32-bit word, driven combinationally during DATA. Lane extraction and sign extension are the CPU load path's job.
  - Next state follows the same acceptance rules as IDLE, so back-to-back transfers are pipelined; otherwise → IDLE.
- ERR1: HREADYOUT=0, HRESP=1; → ERR2.
- ERR2: HREADYOUT=1, HRESP=1; next state follows the IDLE acceptance rules.
- S_HRDATA outside a read DATA cycle: holds its last value (0 after reset).

Latency:
- Read data is valid 1+WAIT_STATES cycles after the address phase.
- An error response lasts exactly 2 cycles.

Hazards:
- Write immediately followed by a read of the same word returns the new data, because the write commits at the edge that begins the read's data phase.
- Write to word W followed by a byte write to W merges correctly: read-modify on the array, no stale captured copy.

Reset mid-transfer: aborts the transfer; any write not yet committed is lost; outputs go to reset values.

Test Plan:
- Word write 32'hDEADBEEF to 32'h1000_0010, then word read same address, WAIT_STATES=0 → read data phase S_HREADYOUT=1, S_HRDATA=32'hDEADBEEF, S_HRESP=0, each transfer completes 1 cycle after its address phase.
- Byte write 32'h0000_AA00 (HSIZE=0) to 32'h1000_0011 over word 32'h11223344, then word read → S_HRDATA=32'h1122AA44.
- Half write 32'h5566_0000 (HSIZE=1) to 32'h1000_0012 → subsequent read 32'h55663344 (old 11223344).
- Word read at 32'h1000_0002 → ERR1 (S_HREADYOUT=0, S_HRESP=1), then ERR2 (S_HREADYOUT=1, S_HRESP=1), SRAM unchanged. Word read at 32'h2000_0000 → same two-cycle ERROR. HSIZE=3 → same two-cycle ERROR.
- WAIT_STATES=2, word read → S_HREADYOUT low for exactly 2 cycles, then high with data. Address phase of the next NONSEQ held on the bus during the waits is accepted only on the S_HREADY=1 cycle.
- Assert rst low during WAIT of a write → S_HREADYOUT=1, S_HRESP=0, S_HRDATA=0 immediately, target word unmodified. HTRANS=IDLE/BUSY with S_HSEL=1 → zero-wait OKAY, no access.
